// File: rtl/step_seq_pkg.sv
// Shared types and helpers for the step-pattern sequencer.
package step_seq_pkg;

   // Sequencer states: IDLE holds outputs, RUN steps through the table.
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Ceiling log2, used to size table indices from DEPTH.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/step_pattern_seq_if.sv
// Control, table-write and output bundle of the step-pattern sequencer.
import step_seq_pkg::*;

interface step_pattern_seq_if #(
   parameter int NCH   = 4,
   parameter int W     = 3,
   parameter int DEPTH = 8,
   parameter int DIV_W = 8
);
   localparam int AW = clog2(DEPTH);

   logic             start;
   logic             stop;
   logic             en;
   logic             dir;
   logic             oneshot;
   logic [DIV_W-1:0] div;
   logic [AW-1:0]    last_idx;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [NCH*W-1:0] wr_val;
   logic [NCH-1:0]   wr_mask;
   logic [NCH*W-1:0] dout;
   logic [AW-1:0]    step_idx;
   logic             step_pulse;
   logic             wrap;
   logic             busy;

   modport master (
      output start, stop, en, dir, oneshot, div, last_idx,
      output wr_en, wr_addr, wr_val, wr_mask,
      input  dout, step_idx, step_pulse, wrap, busy
   );

   modport slave (
      input  start, stop, en, dir, oneshot, div, last_idx,
      input  wr_en, wr_addr, wr_val, wr_mask,
      output dout, step_idx, step_pulse, wrap, busy
   );
endinterface

// File: rtl/step_prescaler.sv
// Step-rate prescaler: one tick every div+1 enabled cycles while running.
module step_prescaler #(
   parameter int DIV_W = 8
) (
   input  logic             ck,
   input  logic             reset,
   input  logic             run,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);
   logic [DIV_W-1:0] count_reg;

   // >= rather than == so a divisor lowered below the count still ticks once and clears.
   assign tick = run & en & ~clr & (count_reg >= div);

   // Count enabled cycles; a (re)start clears the phase, en=0 freezes it.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset)
         count_reg <= '0;
      else if (clr)
         count_reg <= '0;
      else if (run && en)
         count_reg <= (count_reg >= div) ? '0 : count_reg + DIV_W'(1);
   end
endmodule

// File: rtl/step_pattern_seq.sv
// Multi-channel step-pattern sequencer: plays a masked value table at a prescaled rate.
import step_seq_pkg::*;

module step_pattern_seq #(
   parameter int               NCH   = 4,
   parameter int               W     = 3,
   parameter int               DEPTH = 8,
   parameter int               DIV_W = 8,
   parameter logic [NCH*W-1:0] INIT  = 12'h1B0
) (
   input logic               ck,
   input logic               reset,
   step_pattern_seq_if.slave bus
);
   localparam int AW = clog2(DEPTH);

   typedef struct packed {
      logic [NCH*W-1:0] val;
      logic [NCH-1:0]   mask;
   } entry_t;

   entry_t           tbl_mem [DEPTH];
   entry_t           cur;
   state_t           state_reg;
   logic [NCH*W-1:0] dout_reg;
   logic [NCH*W-1:0] applied;
   logic [AW-1:0]    step_idx_reg;
   logic [AW-1:0]    last_eff;
   logic [AW-1:0]    next_idx;
   logic             step_pulse_reg;
   logic             wrap_reg;
   logic             tick;
   logic             wrap_now;
   logic             final_now;
   logic             wr_ok;

   // Out-of-range last_idx clamps to the final table entry; out-of-range writes are dropped.
   assign last_eff = ({1'b0, bus.last_idx} >= (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : bus.last_idx;
   assign wr_ok    = ({1'b0, bus.wr_addr} < (AW+1)'(DEPTH));

   // Read is combinational, so a write landing on the ticking entry still applies the old entry.
   assign cur = tbl_mem[step_idx_reg];

   // Table store; writable in any state, cleared by reset.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) tbl_mem[i] <= '0;
      end else if (bus.wr_en && wr_ok) begin
         tbl_mem[bus.wr_addr] <= '{val: bus.wr_val, mask: bus.wr_mask};
      end
   end

   // Per-channel merge: masked channels load the entry value, the rest keep their output.
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      assign applied[gi*W +: W] = cur.mask[gi] ? cur.val[gi*W +: W] : dout_reg[gi*W +: W];
   end

   // Index advance and end-of-pass detection for the current direction.
   always_comb begin
      wrap_now  = 1'b0;
      final_now = 1'b0;
      next_idx  = step_idx_reg;
      if (bus.dir) begin
         wrap_now  = (step_idx_reg == '0) || (step_idx_reg > last_eff);
         final_now = (step_idx_reg == '0);
         next_idx  = wrap_now ? last_eff : step_idx_reg - AW'(1);
      end else begin
         wrap_now  = (step_idx_reg >= last_eff);
         final_now = wrap_now;
         next_idx  = wrap_now ? '0 : step_idx_reg + AW'(1);
      end
   end

   step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
      .ck    (ck),
      .reset (reset),
      .run   (state_reg == RUN),
      .en    (bus.en),
      .clr   (bus.start),
      .div   (bus.div),
      .tick  (tick)
   );

   // Control FSM: stop beats start, start beats a pending tick, ticks apply one entry.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         dout_reg       <= INIT;
         step_idx_reg   <= '0;
         step_pulse_reg <= 1'b0;
         wrap_reg       <= 1'b0;
      end else begin
         step_pulse_reg <= 1'b0;
         wrap_reg       <= 1'b0;
         if (bus.stop) begin
            state_reg <= IDLE;
         end else if (bus.start) begin
            state_reg    <= RUN;
            step_idx_reg <= bus.dir ? last_eff : '0;
         end else if (tick) begin
            dout_reg       <= applied;
            step_idx_reg   <= next_idx;
            step_pulse_reg <= 1'b1;
            wrap_reg       <= wrap_now;
            if (bus.oneshot && final_now) state_reg <= IDLE;
         end
      end
   end

   assign bus.dout       = dout_reg;
   assign bus.step_idx   = step_idx_reg;
   assign bus.step_pulse = step_pulse_reg;
   assign bus.wrap       = wrap_reg;
   assign bus.busy       = (state_reg == RUN);
endmodule

// File: tb/tb_step_pattern_seq.sv
// Directed bench for step_pattern_seq: an 8-deep instance plus a 6-deep one for index clamping.
module tb_step_pattern_seq;
   logic ck = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [11:0] pat [8] = '{12'h123, 12'h456, 12'h789, 12'hABC,
                            12'hDEF, 12'h135, 12'h246, 12'h9AC};

   always #5 ck = ~ck;

   step_pattern_seq_if #(.NCH(4), .W(3), .DEPTH(8), .DIV_W(8)) b8 ();
   step_pattern_seq_if #(.NCH(4), .W(3), .DEPTH(6), .DIV_W(8)) b6 ();

   step_pattern_seq #(.NCH(4), .W(3), .DEPTH(8), .DIV_W(8), .INIT(12'h1B0)) dut8 (
      .ck(ck), .reset(reset), .bus(b8)
   );
   step_pattern_seq #(.NCH(4), .W(3), .DEPTH(6), .DIV_W(8), .INIT(12'h1B0)) dut6 (
      .ck(ck), .reset(reset), .bus(b6)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr8(input logic [2:0] a, input logic [11:0] v, input logic [3:0] m);
      b8.wr_en = 1'b1; b8.wr_addr = a; b8.wr_val = v; b8.wr_mask = m;
      @(negedge ck);
      b8.wr_en = 1'b0;
   endtask

   task automatic wr6(input logic [2:0] a, input logic [11:0] v, input logic [3:0] m);
      b6.wr_en = 1'b1; b6.wr_addr = a; b6.wr_val = v; b6.wr_mask = m;
      @(negedge ck);
      b6.wr_en = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      b8.start = 0; b8.stop = 0; b8.en = 0; b8.dir = 0; b8.oneshot = 0; b8.div = 0;
      b8.last_idx = 0; b8.wr_en = 0; b8.wr_addr = 0; b8.wr_val = 0; b8.wr_mask = 0;
      b6.start = 0; b6.stop = 0; b6.en = 0; b6.dir = 0; b6.oneshot = 0; b6.div = 0;
      b6.last_idx = 0; b6.wr_en = 0; b6.wr_addr = 0; b6.wr_val = 0; b6.wr_mask = 0;

      // 1: reset values
      @(negedge ck);
      chk("rst_dout", b8.dout, 12'h1B0);
      chk("rst_idx", b8.step_idx, 0);
      chk("rst_busy", b8.busy, 0);
      chk("rst_pulse", b8.step_pulse, 0);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) wr8(3'(i), pat[i], 4'hF);
      for (int i = 0; i < 6; i++) wr6(3'(i), 12'(i + 1), 4'hF);

      // 2: legacy pattern, div=0, loop, forward
      b8.div = 0; b8.dir = 0; b8.oneshot = 0; b8.last_idx = 3'd7; b8.en = 1;
      b8.start = 1;
      @(negedge ck);
      b8.start = 0;
      chk("t2_busy", b8.busy, 1);
      chk("t2_hold", b8.dout, 12'h1B0);
      chk("t2_idx0", b8.step_idx, 0);
      for (int k = 0; k < 16; k++) begin
         @(negedge ck);
         chk("t2_dout", b8.dout, pat[k % 8]);
         chk("t2_idx", b8.step_idx, (k + 1) % 8);
         chk("t2_wrap", b8.wrap, (k % 8 == 7));
         chk("t2_pulse", b8.step_pulse, 1);
      end
      b8.stop = 1;
      @(negedge ck);
      b8.stop = 0;
      chk("t2_stop_busy", b8.busy, 0);
      chk("t2_stop_dout", b8.dout, pat[7]);
      chk("t2_stop_pulse", b8.step_pulse, 0);
      @(negedge ck);
      chk("t2_idle_dout", b8.dout, pat[7]);
      chk("t2_idle_idx", b8.step_idx, 0);

      // 3: div=3, then freeze with en=0 mid-count
      b8.div = 8'd3;
      b8.start = 1;
      @(negedge ck);
      b8.start = 0;
      chk("t3_pulse", b8.step_pulse, 0);
      for (int n = 2; n <= 9; n++) begin
         @(negedge ck);
         chk("t3_pulse", b8.step_pulse, (n == 5 || n == 9));
         if (n == 5) chk("t3_dout0", b8.dout, pat[0]);
      end
      chk("t3_dout1", b8.dout, pat[1]);
      chk("t3_idx", b8.step_idx, 2);
      @(negedge ck);
      chk("t3_pulse_pre", b8.step_pulse, 0);
      b8.en = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge ck);
         chk("t3_frz_pulse", b8.step_pulse, 0);
         chk("t3_frz_dout", b8.dout, pat[1]);
         chk("t3_frz_idx", b8.step_idx, 2);
      end
      b8.en = 1;
      @(negedge ck);
      chk("t3_post_pulse", b8.step_pulse, 0);
      @(negedge ck);
      chk("t3_post_pulse", b8.step_pulse, 0);
      @(negedge ck);
      chk("t3_resume_pulse", b8.step_pulse, 1);
      chk("t3_resume_dout", b8.dout, pat[2]);
      b8.stop = 1;
      @(negedge ck);
      b8.stop = 0;

      // 4: one-shot, reverse, last_idx=4
      b8.div = 0; b8.dir = 1; b8.oneshot = 1; b8.last_idx = 3'd4;
      b8.start = 1;
      @(negedge ck);
      b8.start = 0;
      chk("t4_busy", b8.busy, 1);
      chk("t4_idx", b8.step_idx, 4);
      for (int j = 0; j < 5; j++) begin
         @(negedge ck);
         chk("t4_dout", b8.dout, pat[4 - j]);
         chk("t4_wrap", b8.wrap, (j == 4));
         chk("t4_busy", b8.busy, (j != 4));
      end
      @(negedge ck);
      chk("t4_end_pulse", b8.step_pulse, 0);
      chk("t4_end_busy", b8.busy, 0);
      chk("t4_end_idx", b8.step_idx, 4);
      chk("t4_end_dout", b8.dout, pat[0]);

      // 5: mask 0101 over dout=0x123 -> ch0,ch2 load 7, ch1,ch3 hold
      wr8(3'd0, 12'hFFF, 4'b0101);
      b8.dir = 0; b8.last_idx = 3'd0; b8.oneshot = 1;
      b8.start = 1;
      @(negedge ck);
      b8.start = 0;
      @(negedge ck);
      chk("t5_dout", b8.dout, 12'h1E7);
      chk("t5_pulse", b8.step_pulse, 1);
      chk("t5_wrap", b8.wrap, 1);
      chk("t5_busy", b8.busy, 0);

      // 6a: start and stop together stay in IDLE
      b8.start = 1; b8.stop = 1;
      @(negedge ck);
      b8.start = 0; b8.stop = 0;
      chk("t6_ss_busy", b8.busy, 0);
      chk("t6_ss_dout", b8.dout, 12'h1E7);
      @(negedge ck);
      chk("t6_ss_busy2", b8.busy, 0);

      // 6b: DEPTH=6 instance, last_idx=7 clamps to 5
      b6.div = 0; b6.dir = 0; b6.oneshot = 0; b6.last_idx = 3'd7; b6.en = 1;
      b6.start = 1;
      @(negedge ck);
      b6.start = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge ck);
         chk("t6_clamp_dout", b6.dout, (k % 6) + 1);
         chk("t6_clamp_wrap", b6.wrap, (k % 6 == 5));
      end
      b6.stop = 1;
      @(negedge ck);
      b6.stop = 0;

      // 6c: write entry 2 during its own tick
      wr8(3'd0, pat[0], 4'hF);
      b8.dir = 0; b8.oneshot = 0; b8.last_idx = 3'd7; b8.div = 0;
      b8.start = 1;
      @(negedge ck);
      b8.start = 0;
      @(negedge ck);
      chk("t6_wr_d0", b8.dout, pat[0]);
      @(negedge ck);
      chk("t6_wr_d1", b8.dout, pat[1]);
      wr8(3'd2, 12'h555, 4'hF);
      chk("t6_wr_old", b8.dout, pat[2]);
      repeat (8) @(negedge ck);
      chk("t6_wr_new", b8.dout, 12'h555);

      // 1b: asynchronous reset mid-run
      #2;
      reset = 1'b0;
      #1;
      chk("t1_arst_dout", b8.dout, 12'h1B0);
      chk("t1_arst_idx", b8.step_idx, 0);
      chk("t1_arst_busy", b8.busy, 0);
      chk("t1_arst_pulse", b8.step_pulse, 0);
      @(negedge ck);
      reset = 1'b1;
      @(negedge ck);
      chk("t1_post_busy", b8.busy, 0);
      chk("t1_post_dout", b8.dout, 12'h1B0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
